// File: rtl/hex_byte_scroller_if.sv
// Bus between the UART-side byte source and the hex display scheduler.
// The master drives received bytes and controls; the slave drives the display.
interface hex_byte_scroller_if #(
    parameter int unsigned DEPTH = 4
);
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic                     hold;
    logic                     clear;
    logic [7:0]               disp_byte;
    logic [$clog2(DEPTH)-1:0] disp_idx;
    logic                     disp_blank;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output rx_data, rx_valid, hold, clear,
        input  disp_byte, disp_idx, disp_blank, count
    );

    modport slave (
        input  rx_data, rx_valid, hold, clear,
        output disp_byte, disp_idx, disp_blank, count
    );
endinterface

// File: rtl/hex_byte_scroller.sv
// Byte history buffer plus display scheduler for a two-digit hex 7-segment decoder.
// A new byte is shown at once; otherwise older bytes scroll past on a dwell timer.
module hex_byte_scroller #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DWELL_CYCLES = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    hex_byte_scroller_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(DWELL_CYCLES);

    typedef enum logic [1:0] {EMPTY, SHOW_NEW, SCROLL} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    state_t        state, state_nx;
    logic [AW-1:0] disp_idx, idx_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          pending, pending_nx;
    logic [7:0]    disp_byte, byte_nx;
    logic          disp_blank, blank_nx;
    logic          load_mem;
    logic          expire;
    logic [AW-1:0] rd_addr;

    assign bus.disp_byte  = disp_byte;
    assign bus.disp_idx   = disp_idx;
    assign bus.disp_blank = disp_blank;
    assign bus.count      = count;

    always_ff @(posedge clk) begin
        if (bus.rx_valid && !bus.clear)
            mem[wr_ptr] <= bus.rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.clear) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.rx_valid) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (count != CW'(DEPTH))
                count <= count + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            disp_idx   <= '0;
            timer      <= '0;
            pending    <= 1'b0;
            disp_byte  <= 8'h00;
            disp_blank <= 1'b1;
        end else begin
            state      <= state_nx;
            disp_idx   <= idx_nx;
            timer      <= timer_nx;
            pending    <= pending_nx;
            disp_byte  <= byte_nx;
            disp_blank <= blank_nx;
        end
    end

    // The displayed byte is loaded from the age chosen for the next cycle, so
    // disp_byte and disp_idx always change together on the same edge.
    always_comb begin
        state_nx   = state;
        idx_nx     = disp_idx;
        timer_nx   = timer;
        pending_nx = pending;
        byte_nx    = disp_byte;
        blank_nx   = disp_blank;
        load_mem   = 1'b0;
        expire     = (timer == TW'(DWELL_CYCLES - 1));

        if (bus.clear) begin
            state_nx   = EMPTY;
            idx_nx     = '0;
            timer_nx   = '0;
            pending_nx = 1'b0;
            byte_nx    = 8'h00;
            blank_nx   = 1'b1;
        end else if (bus.hold) begin
            if (bus.rx_valid)
                pending_nx = 1'b1;
        end else if (bus.rx_valid || pending) begin
            state_nx   = SHOW_NEW;
            idx_nx     = '0;
            timer_nx   = '0;
            pending_nx = 1'b0;
            blank_nx   = 1'b0;
            if (bus.rx_valid)
                byte_nx = bus.rx_data;
            else
                load_mem = 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    idx_nx   = '0;
                    timer_nx = '0;
                    byte_nx  = 8'h00;
                    blank_nx = 1'b1;
                end
                SHOW_NEW: begin
                    load_mem = 1'b1;
                    if (!expire) begin
                        timer_nx = timer + TW'(1);
                    end else begin
                        timer_nx = '0;
                        if (count > CW'(1)) begin
                            idx_nx   = AW'(1);
                            state_nx = SCROLL;
                        end
                    end
                end
                SCROLL: begin
                    load_mem = 1'b1;
                    if (!expire) begin
                        timer_nx = timer + TW'(1);
                    end else begin
                        timer_nx = '0;
                        if ({1'b0, disp_idx} == count - CW'(1))
                            idx_nx = '0;
                        else
                            idx_nx = disp_idx + AW'(1);
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end

        rd_addr = wr_ptr - AW'(1) - idx_nx;
        if (load_mem)
            byte_nx = mem[rd_addr];
    end
endmodule

// File: tb/tb_hex_byte_scroller.sv
// Randomized self-checking bench for hex_byte_scroller against a queue-based history model.
module tb_hex_byte_scroller;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DWELL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hex_byte_scroller_if #(.DEPTH(DEPTH)) bus ();

    hex_byte_scroller #(.DEPTH(DEPTH), .DWELL_CYCLES(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: history held newest-first; display described by age and elapsed dwell.
    logic [7:0]  m_hist [$];
    int unsigned m_age;
    int unsigned m_elapsed;
    logic        m_pending;
    logic        m_blank;
    logic [7:0]  m_shown;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        m_hist.delete();
        m_age = 0; m_elapsed = 0; m_pending = 1'b0; m_blank = 1'b1; m_shown = 8'h00;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] d, input logic h, input logic c);
        if (c) begin
            model_reset();
            return;
        end
        if (v) begin
            m_hist.push_front(d);
            if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
        end
        if (h) begin
            if (v) m_pending = 1'b1;
        end else if (v || m_pending) begin
            m_pending = 1'b0; m_blank = 1'b0; m_age = 0; m_elapsed = 0;
            m_shown = m_hist[0];
        end else if (!m_blank) begin
            if (m_elapsed == DWELL - 1) begin
                m_elapsed = 0;
                m_age = (m_age + 1) % m_hist.size();
            end else begin
                m_elapsed++;
            end
            m_shown = m_hist[m_age];
        end
    endfunction

    task automatic compare_all();
        check_eq("disp_byte",  32'(bus.disp_byte),  32'(m_shown));
        check_eq("disp_idx",   32'(bus.disp_idx),   m_age);
        check_eq("disp_blank", 32'(bus.disp_blank), 32'(m_blank));
        check_eq("count",      32'(bus.count),      m_hist.size());
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic h, input logic c);
        bus.rx_valid = v; bus.rx_data = d; bus.hold = h; bus.clear = c;
        @(posedge clk);
        model_step(v, d, h, c);
        #1;
        compare_all();
        bus.rx_valid = 1'b0; bus.clear = 1'b0;
    endtask

    task automatic idle(input int unsigned n, input logic h);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 8'h00, h, 1'b0);
    endtask

    logic h_rand;

    initial begin
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.hold = 1'b0; bus.clear = 1'b0;
        model_reset();
        #12;
        compare_all();
        check_eq("reset_blank", 32'(bus.disp_blank), 32'd1);
        @(posedge clk); #1; rst = 1'b0;

        // Single byte stays on idx 0 indefinitely.
        step(1'b1, 8'h3A, 1'b0, 1'b0);
        check_eq("t1_byte", 32'(bus.disp_byte), 32'h3A);
        idle(20, 1'b0);
        check_eq("t1_still", 32'(bus.disp_byte), 32'h3A);

        // Three bytes then scroll through them.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t2_idx1", 32'(bus.disp_byte), 32'h22);
        idle(16, 1'b0);

        // Overflow: five bytes into four entries.
        for (int unsigned i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check_eq("t3_count", 32'(bus.count), 32'd4);
        idle(9, 1'b0);
        check_eq("t3_idx2", 32'(bus.disp_byte), 32'h03);
        // New byte mid-scroll restarts a full dwell on idx 0.
        step(1'b1, 8'hAB, 1'b0, 1'b0);
        check_eq("t4_new", 32'(bus.disp_byte), 32'hAB);
        idle(6, 1'b0);

        // Hold while showing an older byte, with a byte arriving under hold.
        idle(2, 1'b1);
        step(1'b1, 8'hCC, 1'b1, 1'b0);
        idle(10, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t5_release", 32'(bus.disp_byte), 32'hCC);
        idle(5, 1'b0);

        // Hold across EMPTY, then clear colliding with a strobe.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h5E, 1'b1, 1'b0);
        idle(3, 1'b1);
        check_eq("t5_empty_blank", 32'(bus.disp_blank), 32'd1);
        idle(3, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b1);
        check_eq("t6_clear_cnt", 32'(bus.count), 32'd0);
        idle(2, 1'b0);

        // Randomized traffic.
        h_rand = 1'b0;
        for (int unsigned i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) h_rand = ~h_rand;
            step(($urandom_range(0, 9) == 0), 8'($urandom), h_rand,
                 ($urandom_range(0, 149) == 0));
        end

        // Asynchronous reset between clock edges, mid-dwell.
        step(1'b1, 8'h9C, 1'b0, 1'b0);
        step(1'b1, 8'h9D, 1'b0, 1'b0);
        idle(2, 1'b1);
        #2; rst = 1'b1; #1;
        model_reset();
        compare_all();
        @(posedge clk); #1; rst = 1'b0;
        step(1'b1, 8'h42, 1'b0, 1'b0);
        idle(6, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
